ui_input_conditioner: RTL and testbench

UI_INPUT_CONDITIONER -- requirements
Module: ui_input_conditioner

---
 rtl/ui_pkg.sv | 18 +
 rtl/ui_debounce_channel.sv | 129 ++++++++++++
 rtl/ui_input_conditioner.sv | 41 ++++
 tb/tb_ui_input_conditioner.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ui_pkg.sv
// Shared constants and state encoding for the UI input conditioner.
// Imported by the channel and top-level modules.
package ui_pkg;

    localparam logic [1:0] ST_STABLE_LO = 2'd0;
    localparam logic [1:0] ST_PEND_HI   = 2'd1;
    localparam logic [1:0] ST_STABLE_HI = 2'd2;
    localparam logic [1:0] ST_PEND_LO   = 2'd3;

    localparam int CLK_HZ        = 100000000;
    localparam int DEBOUNCE_10MS = CLK_HZ / 100;
    localparam int LONG_PRESS_1S = CLK_HZ;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ui_debounce_channel.sv
// One conditioned input: synchroniser, debounce FSM, hold counter,
// edge pulses and push-on/push-off toggle.
module ui_debounce_channel
    import ui_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES   = DEBOUNCE_10MS,
    parameter int         LONG_PRESS_CYCLES = LONG_PRESS_1S,
    parameter logic       ACTIVE_LOW        = 1'b0,
    parameter int         CW                = 32
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_long,
    output logic o_toggle
);

    localparam int D_LAST = DEBOUNCE_CYCLES - 1;
    localparam int L_LAST = (LONG_PRESS_CYCLES > 0) ? LONG_PRESS_CYCLES - 1 : 0;
    localparam logic LONG_EN = (LONG_PRESS_CYCLES > 0);

    logic          s1_q, s2_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] hold_q, hold_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          long_q, long_d;
    logic          toggle_q, toggle_d;

    logic          in_pol;
    logic          hold_sat;
    logic          hold_hit;

    assign in_pol   = i_raw ^ ACTIVE_LOW;
    assign hold_sat = &hold_q;
    assign hold_hit = LONG_EN && (hold_q == CW'(L_LAST));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        long_d   = 1'b0;
        toggle_d = toggle_q;
        unique case (state_q)
            ST_STABLE_LO: begin
                if (s2_q) begin
                    state_d = ST_PEND_HI;
                    cnt_d   = '0;
                end
            end
            ST_PEND_HI: begin
                if (!s2_q) begin
                    state_d = ST_STABLE_LO;
                end else if (cnt_q == CW'(D_LAST)) begin
                    state_d  = ST_STABLE_HI;
                    level_d  = 1'b1;
                    rise_d   = 1'b1;
                    toggle_d = ~toggle_q;
                    hold_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STABLE_HI: begin
                if (!hold_sat) hold_d = hold_q + 1'b1;
                long_d = hold_hit;
                if (!s2_q) begin
                    state_d = ST_PEND_LO;
                    cnt_d   = '0;
                end
            end
            default: begin
                // PEND_LO keeps timing the hold; bouncing back never re-arms it
                if (!hold_sat) hold_d = hold_q + 1'b1;
                long_d = hold_hit;
                if (s2_q) begin
                    state_d = ST_STABLE_HI;
                end else if (cnt_q == CW'(D_LAST)) begin
                    state_d = ST_STABLE_LO;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            state_q  <= ST_STABLE_LO;
            cnt_q    <= '0;
            hold_q   <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            long_q   <= 1'b0;
            toggle_q <= 1'b0;
        end else begin
            s1_q     <= in_pol;
            s2_q     <= s1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            long_q   <= long_d;
            toggle_q <= toggle_d;
        end
    end

    assign o_level  = level_q;
    assign o_rise   = rise_q;
    assign o_fall   = fall_q;
    assign o_long   = long_q;
    assign o_toggle = toggle_q;

endmodule

// File: rtl/ui_input_conditioner.sv
// Multi-channel switch/button conditioner: one independent
// debounce channel per input pin.
module ui_input_conditioner
    import ui_pkg::*;
#(
    parameter int              N_CH              = 4,
    parameter int              DEBOUNCE_CYCLES   = DEBOUNCE_10MS,
    parameter int              LONG_PRESS_CYCLES = LONG_PRESS_1S,
    parameter logic [N_CH-1:0] ACTIVE_LOW_MASK   = '0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [N_CH-1:0] i_raw,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_rise,
    output logic [N_CH-1:0] o_fall,
    output logic [N_CH-1:0] o_long,
    output logic [N_CH-1:0] o_toggle
);

    localparam int CW = $clog2(max_int(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES)) + 1;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        ui_debounce_channel #(
            .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
            .ACTIVE_LOW        (ACTIVE_LOW_MASK[g]),
            .CW                (CW)
        ) u_ch (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_raw    (i_raw[g]),
            .o_level  (o_level[g]),
            .o_rise   (o_rise[g]),
            .o_fall   (o_fall[g]),
            .o_long   (o_long[g]),
            .o_toggle (o_toggle[g])
        );
    end

endmodule

// File: tb/tb_ui_input_conditioner.sv
// Directed bench for ui_input_conditioner with short debounce and
// long-press settings; expected timing is hand-derived.
module tb_ui_input_conditioner;

    logic       i_clk;
    logic       i_rst_n;
    logic [3:0] i_raw;
    logic [3:0] o_level, o_rise, o_fall, o_long, o_toggle;

    int nvec;
    int nerr;

    ui_input_conditioner #(
        .N_CH              (4),
        .DEBOUNCE_CYCLES   (4),
        .LONG_PRESS_CYCLES (10),
        .ACTIVE_LOW_MASK   (4'b0010)
    ) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_raw    (i_raw),
        .o_level  (o_level),
        .o_rise   (o_rise),
        .o_fall   (o_fall),
        .o_long   (o_long),
        .o_toggle (o_toggle)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_raw   = 4'b0010;
        idle(2);
        if ({o_level, o_rise, o_fall, o_long, o_toggle} !== 20'h0) begin
            nerr++;
            $display("FAIL reset_outs got=%h want=00000",
                     {o_level, o_rise, o_fall, o_long, o_toggle});
        end
        nvec++;
        i_rst_n = 1'b1;
        idle(10);
        if (o_level !== 4'b0000) begin
            nerr++;
            $display("FAIL reset_idle_level got=%b want=0000", o_level);
        end
        nvec++;
    endtask

    task automatic test_clean_press();
        i_raw[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (o_level[0] !== (k >= 7) || o_rise[0] !== (k == 7)) begin
                nerr++;
                $display("FAIL press_edge k=%0d lvl=%b rise=%b want=%b/%b",
                         k, o_level[0], o_rise[0], k >= 7, k == 7);
            end
            nvec++;
        end
        if (o_toggle[0] !== 1'b1) begin
            nerr++;
            $display("FAIL press_toggle got=%b want=1", o_toggle[0]);
        end
        nvec++;
        idle(12);
        i_raw[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (o_level[0] !== (k < 7) || o_fall[0] !== (k == 7)) begin
                nerr++;
                $display("FAIL release_edge k=%0d lvl=%b fall=%b want=%b/%b",
                         k, o_level[0], o_fall[0], k < 7, k == 7);
            end
            nvec++;
        end
        idle(5);
    endtask

    task automatic test_bounce();
        int rises;
        rises = 0;
        for (int i = 0; i < 10; i++) begin
            i_raw[0] = (i % 2 == 0);
            tick();
            rises += o_rise[0];
            if (o_level[0] !== 1'b0 || o_rise[0] !== 1'b0) begin
                nerr++;
                $display("FAIL bounce_quiet i=%0d lvl=%b rise=%b want=0/0",
                         i, o_level[0], o_rise[0]);
            end
            nvec++;
        end
        i_raw[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            rises += o_rise[0];
            if (o_level[0] !== (k >= 7)) begin
                nerr++;
                $display("FAIL bounce_settle k=%0d lvl=%b want=%b",
                         k, o_level[0], k >= 7);
            end
            nvec++;
        end
        if (rises != 1 || o_toggle[0] !== 1'b0) begin
            nerr++;
            $display("FAIL bounce_rises got=%0d tog=%b want=1 tog=0",
                     rises, o_toggle[0]);
        end
        nvec++;
        i_raw[0] = 1'b0;
        idle(12);
    endtask

    task automatic test_glitch();
        int seen;
        seen = 0;
        i_raw[2] = 1'b1;
        idle(3);
        i_raw[2] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            seen |= (o_level[2] | o_rise[2] | o_fall[2]);
            tick();
        end
        seen |= (o_level[2] | o_rise[2] | o_fall[2]);
        if (seen != 0) begin
            nerr++;
            $display("FAIL glitch got=%0d want=0", seen);
        end
        nvec++;
    endtask

    task automatic test_long_press();
        for (int p = 0; p < 2; p++) begin
            int pulses;
            pulses = 0;
            i_raw[3] = 1'b1;
            for (int k = 1; k <= 30; k++) begin
                tick();
                pulses += o_long[3];
                if (o_long[3] !== (k == 17)) begin
                    nerr++;
                    $display("FAIL long p=%0d k=%0d got=%b want=%b",
                             p, k, o_long[3], k == 17);
                end
                nvec++;
            end
            if (pulses != 1) begin
                nerr++;
                $display("FAIL long_count p=%0d got=%0d want=1", p, pulses);
            end
            nvec++;
            i_raw[3] = 1'b0;
            idle(12);
        end
    endtask

    task automatic test_active_low();
        if (o_level[1] !== 1'b0) begin
            nerr++;
            $display("FAIL al_idle got=%b want=0", o_level[1]);
        end
        nvec++;
        i_raw[1] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (o_level[1] !== (k >= 7)) begin
                nerr++;
                $display("FAIL al_press k=%0d got=%b want=%b",
                         k, o_level[1], k >= 7);
            end
            nvec++;
        end
        i_raw[1] = 1'b1;
        idle(12);
    endtask

    task automatic test_reset_mid();
        i_raw[0] = 1'b1;
        idle(5);
        i_rst_n = 1'b0;
        tick();
        if ({o_level, o_rise, o_fall, o_long, o_toggle} !== 20'h0) begin
            nerr++;
            $display("FAIL mid_reset got=%h want=00000",
                     {o_level, o_rise, o_fall, o_long, o_toggle});
        end
        nvec++;
        i_rst_n  = 1'b1;
        i_raw[3] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (o_level[0] !== (k >= 7) || o_level[3] !== (k >= 7) ||
                o_rise[0] !== o_rise[3]) begin
                nerr++;
                $display("FAIL mid_rel k=%0d l0=%b l3=%b r0=%b r3=%b want=%b",
                         k, o_level[0], o_level[3], o_rise[0], o_rise[3], k >= 7);
            end
            nvec++;
        end
        i_raw[0] = 1'b0;
        i_raw[3] = 1'b0;
        idle(12);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_long_press();
        test_active_low();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
